// File: rtl/monitor_transiciones.sv
// Transition monitor: counts toggles on NSIG signals in local counters and, on flush or
// local saturation, adds them into an external 32-bit counter bank by read-modify-write.
// Optional build macro SATURAR_ACUM_EN: saturating accumulate plus sticky saturado flag.
module monitor_transiciones #(
    parameter int unsigned NSIG = 3,
    parameter int unsigned NDIR = 1,
    parameter int unsigned LCW  = 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [NSIG-1:0] senales,
    input  logic            flush,
    output logic [NDIR:0]   dir,
    output logic            LE,
    inout  wire  [31:0]     dato,
    output logic            busy,
    output logic            done
`ifdef SATURAR_ACUM_EN
    ,
    output logic            saturado
`endif
);

    localparam int unsigned DW = NDIR + 1;
    localparam logic [LCW-1:0] CMAX = '1;
    localparam logic [DW-1:0] ULT = DW'(NSIG - 1);

    typedef enum logic [1:0] {IDLE, LEER, ESCRIBIR, FIN} estado_t;

    estado_t         estado_q, estado_d;
    logic [DW-1:0]   idx_q, idx_d;
    logic [DW-1:0]   dir_d;
    logic            le_d, busy_d, done_d;
    logic [NSIG-1:0] prev_q;
    logic            armado_q;
    logic [NSIG-1:0] toggle;
    logic [LCW-1:0]  cnt_q [NSIG];
    logic [LCW-1:0]  cnt_sel;
    logic            any_sat;
    logic [31:0]     hold_q;
    logic [31:0]     wdata;

    // First cycle after reset only loads the edge history, so no spurious toggle is seen.
    assign toggle = armado_q ? (senales ^ prev_q) : '0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev_q   <= '0;
            armado_q <= 1'b0;
        end else begin
            prev_q   <= senales;
            armado_q <= 1'b1;
        end
    end

    // Local counters; the one being written back restarts from this cycle's toggle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NSIG; i++) cnt_q[i] <= '0;
        end else begin
            for (int i = 0; i < NSIG; i++) begin
                if (estado_q == ESCRIBIR && idx_q == DW'(i))
                    cnt_q[i] <= LCW'(toggle[i]);
                else if (toggle[i] && cnt_q[i] != CMAX)
                    cnt_q[i] <= cnt_q[i] + LCW'(1);
            end
        end
    end

    always_comb begin
        cnt_sel = '0;
        any_sat = 1'b0;
        for (int i = 0; i < NSIG; i++) begin
            if (idx_q == DW'(i)) cnt_sel = cnt_q[i];
            if (cnt_q[i] == CMAX) any_sat = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)                 hold_q <= '0;
        else if (estado_q == LEER) hold_q <= dato;
    end

`ifdef SATURAR_ACUM_EN
    logic [32:0] suma;
    assign suma  = {1'b0, hold_q} + 33'(cnt_sel);
    assign wdata = suma[32] ? 32'hFFFF_FFFF : suma[31:0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset)                                saturado <= 1'b0;
        else if (estado_q == ESCRIBIR && suma[32]) saturado <= 1'b1;
    end
`else
    assign wdata = hold_q + 32'(cnt_sel);
`endif

    assign dato = LE ? {32{1'bz}} : wdata;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            estado_q <= IDLE;
            idx_q    <= '0;
            LE       <= 1'b1;
            dir      <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            estado_q <= estado_d;
            idx_q    <= idx_d;
            LE       <= le_d;
            dir      <= dir_d;
            busy     <= busy_d;
            done     <= done_d;
        end
    end

    // Bank-facing outputs are decoded from the next state so they are registered.
    always_comb begin
        estado_d = estado_q;
        idx_d    = idx_q;
        le_d     = 1'b1;
        busy_d   = 1'b0;
        done_d   = 1'b0;
        dir_d    = '0;
        unique case (estado_q)
            IDLE: begin
                if (flush || any_sat) begin
                    estado_d = LEER;
                    idx_d    = '0;
                end
            end
            LEER:     estado_d = ESCRIBIR;
            ESCRIBIR: begin
                if (idx_q == ULT) begin
                    estado_d = FIN;
                end else begin
                    idx_d    = idx_q + DW'(1);
                    estado_d = LEER;
                end
            end
            FIN:      estado_d = IDLE;
            default:  estado_d = IDLE;
        endcase
        le_d   = (estado_d != ESCRIBIR);
        busy_d = (estado_d != IDLE);
        done_d = (estado_d == FIN);
        dir_d  = (estado_d == LEER || estado_d == ESCRIBIR) ? idx_d : '0;
    end

endmodule

// File: tb/tb_monitor_transiciones.sv
// Bench for monitor_transiciones: behavioural counter bank on dato, expected bank writes
// queued by the stimulus and checked by a separate write monitor.
module tb_monitor_transiciones;

    logic        clk;
    logic        reset;
    logic [2:0]  senales;
    logic        flush;
    logic [1:0]  dir;
    logic        LE;
    wire  [31:0] dato;
    logic        busy;
    logic        done;
`ifdef SATURAR_ACUM_EN
    logic        saturado;
`endif

    monitor_transiciones #(.NSIG(3), .NDIR(1), .LCW(8)) dut (
        .clk     (clk),
        .reset   (reset),
        .senales (senales),
        .flush   (flush),
        .dir     (dir),
        .LE      (LE),
        .dato    (dato),
        .busy    (busy),
        .done    (done)
`ifdef SATURAR_ACUM_EN
        ,
        .saturado(saturado)
`endif
    );

    typedef struct packed {
        logic [1:0]  d;
        logic [31:0] v;
    } wr_t;

    wr_t         exp_q [$];
    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] bank [4];
    logic [31:0] pre  [4];
    logic        pre_en;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Counter bank: drives dato on reads, captures on writes.
    assign dato = LE ? bank[dir] : {32{1'bz}};

    always @(posedge clk) begin
        if (pre_en)      bank <= pre;
        else if (!LE)    bank[dir] <= dato;
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Write monitor: each write cycle pops one expected (index, value).
    always @(negedge clk) begin
        if (!reset && LE === 1'b0) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_write: got dir %0d data %0h expected no write", dir, dato);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                check("wr_dir", 32'(dir), 32'(e.d));
                check("wr_data", dato, e.v);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [1:0] d, input logic [31:0] v);
        wr_t e;
        e.d = d;
        e.v = v;
        exp_q.push_back(e);
    endtask

    task automatic toggle(input int s);
        senales[s] = ~senales[s];
        tick();
    endtask

    task automatic preload(input logic [31:0] b0, input logic [31:0] b1, input logic [31:0] b2);
        pre[0] = b0; pre[1] = b1; pre[2] = b2; pre[3] = 32'h0;
        pre_en = 1'b1;
        tick();
        pre_en = 1'b0;
    endtask

    // Runs one sweep (flush-started or already triggered); optionally toggles signal 0
    // during its own write cycle. Checks done latency, write-cycle count and busy length.
    task automatic sweep(input bit do_flush, input bit tog0);
        int  cyc, n_le0, n_busy;
        bit  seen;
        cyc = 0; n_le0 = 0; n_busy = 0; seen = 1'b0;
        if (do_flush) flush = 1'b1;
        while (!seen && cyc < 40) begin
            tick();
            flush = 1'b0;
            cyc++;
            if (LE == 1'b0) n_le0++;
            if (busy) n_busy++;
            if (done) seen = 1'b1;
            if (tog0 && cyc == 2) senales[0] = ~senales[0];
        end
        check("done_latency", 32'(cyc), 32'd7);
        check("le_low_cycles", 32'(n_le0), 32'd3);
        check("busy_cycles", 32'(n_busy), 32'd7);
        tick();
        check("busy_after", 32'(busy), 32'd0);
        check("done_pulse", 32'(done), 32'd0);
    endtask

    initial begin
        reset   = 1'b1;
        senales = 3'b000;
        flush   = 1'b0;
        pre_en  = 1'b0;
        for (int i = 0; i < 4; i++) pre[i] = 32'h0;
        preload(32'd0, 32'd0, 32'd0);
        tick();
        check("rst_le", 32'(LE), 32'd1);
        check("rst_dir", 32'(dir), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
`ifdef SATURAR_ACUM_EN
        check("rst_saturado", 32'(saturado), 32'd0);
`endif
        reset = 1'b0;
        tick();
        tick();

        // 5 toggles on s0, 2 on s2
        for (int k = 0; k < 5; k++) toggle(0);
        for (int k = 0; k < 2; k++) toggle(2);
        push(2'd0, 32'd5); push(2'd1, 32'd0); push(2'd2, 32'd2);
        sweep(1'b1, 1'b0);
        check("bank0_a", bank[0], 32'd5);
        check("bank2_a", bank[2], 32'd2);
        // Local counters were cleared: a second sweep adds nothing
        push(2'd0, 32'd5); push(2'd1, 32'd0); push(2'd2, 32'd2);
        sweep(1'b1, 1'b0);

        // One toggle per signal on a preloaded bank
        preload(32'd100, 32'd200, 32'd300);
        toggle(0); toggle(1); toggle(2);
        push(2'd0, 32'd101); push(2'd1, 32'd201); push(2'd2, 32'd301);
        sweep(1'b1, 1'b0);
        check("bank1_b", bank[1], 32'd201);

        // Local saturation starts a sweep without flush
        push(2'd0, 32'd101); push(2'd1, 32'd456); push(2'd2, 32'd301);
        for (int k = 0; k < 255; k++) toggle(1);
        sweep(1'b0, 1'b0);
        check("bank1_sat", bank[1], 32'd456);

        // Toggle on s0 during its own write survives into the next sweep
        push(2'd0, 32'd101); push(2'd1, 32'd456); push(2'd2, 32'd301);
        sweep(1'b1, 1'b1);
        push(2'd0, 32'd102); push(2'd1, 32'd456); push(2'd2, 32'd301);
        sweep(1'b1, 1'b0);
        check("bank0_d", bank[0], 32'd102);

        // Reset during the read of index 1 abandons the rest of the sweep
        toggle(0); toggle(1); toggle(2);
        push(2'd0, 32'd103);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        tick();
        tick();
        check("mid_dir", 32'(dir), 32'd1);
        reset = 1'b1;
        #1;
        check("mid_rst_le", 32'(LE), 32'd1);
        check("mid_rst_busy", 32'(busy), 32'd0);
        tick();
        tick();
        reset = 1'b0;
        tick();
        tick();
        check("bank0_e", bank[0], 32'd103);
        check("bank1_e", bank[1], 32'd456);
        check("bank2_e", bank[2], 32'd301);

        // Accumulate across the 32-bit boundary
        preload(32'hFFFF_FFFE, 32'd456, 32'd301);
        for (int k = 0; k < 3; k++) toggle(0);
`ifdef SATURAR_ACUM_EN
        push(2'd0, 32'hFFFF_FFFF);
`else
        push(2'd0, 32'h0000_0001);
`endif
        push(2'd1, 32'd456); push(2'd2, 32'd301);
        sweep(1'b1, 1'b0);
`ifdef SATURAR_ACUM_EN
        check("bank0_f", bank[0], 32'hFFFF_FFFF);
        check("saturado", 32'(saturado), 32'd1);
`else
        check("bank0_f", bank[0], 32'h0000_0001);
`endif

        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/monitor_transiciones.md
Name: monitor_transiciones

Overview:
- Upstream producer for the transition counter bank (32-bit counters addressed by dir, read/write strobe LE, bidirectional 32-bit dato).
- Watches NSIG digital signals and counts toggles in small local counters.
- On a flush request, or when any local counter saturates, sweeps every counter index with a read-modify-write: read the bank value, add the local count, write the sum back.

Parameters:
- NSIG, 3, number of monitored signals; one bank counter per signal, index i = signal i.
- NDIR, 1, dir port MSB; dir is [NDIR:0]; requires 2^(NDIR+1) >= NSIG.
- LCW, 8, local toggle counter width in bits.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- senales  input  NSIG  monitored signals, synchronous to clk.
- flush  input  1  one-cycle pulse requesting a sweep.
- dir  output  NDIR+1  counter index to the bank.
- LE  output  1  1 = bank drives dato (read); 0 = this block drives dato (write).
- dato  inout  32  driven by this block only when LE=0, else high-Z.
- busy  output  1  high while a sweep is in progress.
- done  output  1  one-cycle pulse in the cycle after the last write of a sweep.

Behaviour:
- Reset values:
  - LE=1, dir=0, dato high-Z, busy=0, done=0.
  - All local counters = 0; edge-history register = current senales sampled at first clk after reset release (no toggle counted that cycle).
- Toggle detection:
  - Per signal, toggle = senales[i] != prev[i]; prev updated every cycle.
  - Local counter increments by 1 per toggle and saturates at 2^LCW-1.
- Sweep trigger (IDLE only):
  - flush=1, or any local counter reaches 2^LCW-1.
  - flush while busy=1 is ignored; it is not queued.
- FSM states: IDLE, LEER, ESCRIBIR, FIN.
  - IDLE: LE=1, busy=0. On trigger: i=0, dir=0 -> LEER.
  - LEER (1 cycle): dir=i, LE=1; capture dato into a 32-bit holding register at the clock edge -> ESCRIBIR.
  - ESCRIBIR (1 cycle): dir=i, LE=0, dato = holding + local[i] (32-bit, wraps modulo 2^32).
    - At the clock edge, local[i] is cleared to 0, or set to 1 if signal i toggles in this same cycle.
    - If i == NSIG-1 -> FIN; else i=i+1 -> LEER.
  - FIN (1 cycle): LE=1, dir=0, done=1 -> IDLE.
- Timing:
  - busy is high from the cycle after the trigger until FIN inclusive.
  - Sweep length = 2*NSIG+1 cycles.
- Bank interface rules:
  - dir is stable across each LEER/ESCRIBIR pair.
  - LE returns to 1 before dir changes, so the bank never writes a wrong index.
- Toggles keep counting during a sweep. A toggle on signal i after its ESCRIBIR stays in local[i] for the next sweep.
- Reset mid-sweep: FSM returns to IDLE immediately and LE=1 asynchronously; the in-flight write is abandoned and local counts are lost.

Optional Feature:
- Macro: SATURAR_ACUM_EN.
- Defined: the ESCRIBIR sum saturates at 32'hFFFFFFFF instead of wrapping, and a sticky output saturado (1 bit, reset 0) is added. saturado sets when any write saturates and clears only on reset.
- Undefined: the sum wraps modulo 2^32 and the saturado port does not exist.

Test Plan:
- Reset, bank preloaded {0,0,0}: toggle senales[0] 5 times, senales[2] 2 times, pulse flush -> bank becomes {5,0,2}; done pulses exactly 7 cycles after flush; local counters = 0.
- Bank preloaded {100,200,300}: 1 toggle per signal, flush -> bank {101,201,301}; LE=0 only in the 3 ESCRIBIR cycles; dato high-Z whenever LE=1.
- LCW=8: toggle senales[1] 255 times with no flush -> sweep starts automatically; bank[1] += 255.
- Toggle senales[0] during its own ESCRIBIR cycle -> local[0]=1 after the sweep; a second flush adds 1 more.
- Assert reset during LEER of index 1 -> LE=1, busy=0 immediately; bank[1] and bank[2] unchanged.
- Bank[0]=32'hFFFFFFFE, 3 toggles on senales[0], flush -> result 32'h00000001 without SATURAR_ACUM_EN; 32'hFFFFFFFF and saturado=1 with it.
